// File: rtl/decap_rci_mem_arb_pkg.sv
// Shared types and helpers for the RCI hash/value memory arbiter.
// Optional parity protection is enabled by defining RCI_MEM_PARITY_EN.
`ifndef RCI_HASH_TABLE_DEPTH_NBITS
`define RCI_HASH_TABLE_DEPTH_NBITS 3
`endif
`ifndef RCI_HASH_BUCKET_NBITS
`define RCI_HASH_BUCKET_NBITS 64
`endif
`ifndef RCI_VALUE_NBITS
`define RCI_VALUE_NBITS 48
`endif
`ifndef RCI_VALUE_DEPTH_NBITS
`define RCI_VALUE_DEPTH_NBITS 3
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif

package decap_rci_mem_arb_pkg;
  localparam int PIO_WORD_NBITS = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} pio_state_e;

  function automatic int words_per_entry(input int nbits);
    return (nbits + PIO_WORD_NBITS - 1) / PIO_WORD_NBITS;
  endfunction

  function automatic int word_sel_nbits(input int nbits);
    return (words_per_entry(nbits) > 1) ? $clog2(words_per_entry(nbits)) : 0;
  endfunction
endpackage

// File: rtl/decap_rci_mem_arb_if.sv
// PIO register bus plus the hash-table and value app read ports.
// par_err exists only when RCI_MEM_PARITY_EN is defined.
interface decap_rci_mem_arb_if #(
  parameter int NUM_TABLES        = 2,
  parameter int DEPTH_NBITS       = `RCI_HASH_TABLE_DEPTH_NBITS,
  parameter int BUCKET_NBITS      = `RCI_HASH_BUCKET_NBITS,
  parameter int VALUE_NBITS       = `RCI_VALUE_NBITS,
  parameter int VALUE_DEPTH_NBITS = `RCI_VALUE_DEPTH_NBITS
);
  logic [`PIO_RANGE]                 reg_addr, reg_din, reg_rdata;
  logic                              reg_rd, reg_wr, reg_ms_hash, reg_ms_value, reg_ack;
  logic [NUM_TABLES-1:0]             ht_rd, ht_rdy, ht_ack;
  logic [NUM_TABLES*DEPTH_NBITS-1:0] ht_raddr;
  logic [NUM_TABLES*BUCKET_NBITS-1:0] ht_rdata;
  logic                              value_rd, value_rdy, value_ack;
  logic [VALUE_DEPTH_NBITS-1:0]      value_raddr;
  logic [VALUE_NBITS-1:0]            value_rdata;
`ifdef RCI_MEM_PARITY_EN
  logic                              par_err;
`endif

  modport master (
`ifdef RCI_MEM_PARITY_EN
    input par_err,
`endif
    output reg_addr, reg_din, reg_rd, reg_wr, reg_ms_hash, reg_ms_value,
    output ht_rd, ht_raddr, value_rd, value_raddr,
    input reg_rdata, reg_ack, ht_rdy, ht_ack, ht_rdata, value_rdy, value_ack, value_rdata
  );

  modport slave (
`ifdef RCI_MEM_PARITY_EN
    output par_err,
`endif
    input reg_addr, reg_din, reg_rd, reg_wr, reg_ms_hash, reg_ms_value,
    input ht_rd, ht_raddr, value_rd, value_raddr,
    output reg_rdata, reg_ack, ht_rdy, ht_ack, ht_rdata, value_rdy, value_ack, value_rdata
  );
endinterface

// File: rtl/decap_rci_mem_arb_bank.sv
// rci_mem_bank: one app read port (2-cycle pipeline) plus one 32-bit PIO word port.
// With RCI_MEM_PARITY_EN, one even-parity bit per word is stored and checked.
module rci_mem_bank
  import decap_rci_mem_arb_pkg::*;
#(
  parameter int W  = 64,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          app_acc,
  input  logic [AW-1:0] app_raddr,
  output logic          app_ack,
  output logic [W-1:0]  app_rdata,
  input  logic          pio_we,
  input  logic [AW-1:0] pio_entry,
  input  logic [7:0]    pio_word,
  input  logic [31:0]   pio_wdata,
  output logic [31:0]   pio_rdata
`ifdef RCI_MEM_PARITY_EN
  ,
  output logic          app_perr,
  output logic          pio_perr
`endif
);
  localparam int WPE = words_per_entry(W);
  localparam int EW  = WPE * PIO_WORD_NBITS;

  logic [W-1:0]  mem [2**AW];
  logic [EW-1:0] pio_ext, wr_ext;
  logic          s1_vld;
  logic [W-1:0]  s1_data;

  // Entry is widened to whole words so the PIO port can splice one word in.
  always_comb begin
    pio_ext = '0;
    pio_ext[W-1:0] = mem[pio_entry];
    wr_ext = pio_ext;
    wr_ext[pio_word*PIO_WORD_NBITS +: PIO_WORD_NBITS] = pio_wdata;
    pio_rdata = pio_ext[pio_word*PIO_WORD_NBITS +: PIO_WORD_NBITS];
  end

  // Array read and PIO write share an edge, so a colliding app read sees old data.
  always_ff @(posedge clk) begin
    if (pio_we) mem[pio_entry] <= wr_ext[W-1:0];
    if (app_acc) s1_data <= mem[app_raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      app_ack   <= 1'b0;
      app_rdata <= '0;
    end else begin
      s1_vld  <= app_acc;
      app_ack <= s1_vld;
      if (s1_vld) app_rdata <= s1_data;
    end
  end

`ifdef RCI_MEM_PARITY_EN
  logic [WPE-1:0] par [2**AW];
  logic [WPE-1:0] wpar, pnext;
  logic           s1_perr;

  function automatic logic [WPE-1:0] word_par(input logic [W-1:0] d);
    logic [EW-1:0]  e;
    logic [WPE-1:0] p;
    e = '0;
    e[W-1:0] = d;
    p = '0;
    for (int i = 0; i < WPE; i++) p[i] = ^e[i*PIO_WORD_NBITS +: PIO_WORD_NBITS];
    return p;
  endfunction

  always_comb begin
    wpar  = word_par(wr_ext[W-1:0]);
    pnext = par[pio_entry];
    pnext[pio_word] = wpar[pio_word];
  end

  assign pio_perr = |((word_par(pio_ext[W-1:0]) ^ par[pio_entry]) & (WPE'(1) << pio_word));

  always_ff @(posedge clk) begin
    if (pio_we) par[pio_entry] <= pnext;
    if (app_acc) s1_perr <= |(word_par(mem[app_raddr]) ^ par[app_raddr]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) app_perr <= 1'b0;
    else        app_perr <= s1_vld & s1_perr;
  end
`endif
endmodule

// File: rtl/decap_rci_mem_arb.sv
// Arbitrates PIO word access against app reads on the hash banks and value array.
// RCI_MEM_PARITY_EN adds per-word parity and the par_err output.
module decap_rci_mem_arb
  import decap_rci_mem_arb_pkg::*;
#(
  parameter int NUM_TABLES        = 2,
  parameter int DEPTH_NBITS       = `RCI_HASH_TABLE_DEPTH_NBITS,
  parameter int BUCKET_NBITS      = `RCI_HASH_BUCKET_NBITS,
  parameter int VALUE_NBITS       = `RCI_VALUE_NBITS,
  parameter int VALUE_DEPTH_NBITS = `RCI_VALUE_DEPTH_NBITS,
  parameter int STARVE_MAX        = 15
) (
  input logic               clk,
  input logic               `RESET_SIG,
  decap_rci_mem_arb_if.slave bus
);
  localparam int HWB = word_sel_nbits(BUCKET_NBITS);
  localparam int VWB = word_sel_nbits(VALUE_NBITS);
  localparam int CW  = $clog2(STARVE_MAX + 2);
  localparam logic [31:0] HMASK = 32'((1 << HWB) - 1);
  localparam logic [31:0] VMASK = 32'((1 << VWB) - 1);

  pio_state_e state, state_nxt;
  logic [31:0] cap_waddr, cap_din;
  logic        cap_wr, cap_hash;
  logic [CW-1:0] starve;

  logic [31:0] h_bank, v_hi;
  logic [7:0]  h_word, v_word;
  logic [DEPTH_NBITS-1:0]       h_ent;
  logic [VALUE_DEPTH_NBITS-1:0] v_ent;
  logic h_in, v_in, in_range, tgt_rd, force_gnt, pio_we, vsel;
  logic [NUM_TABLES-1:0] hsel;
  logic [NUM_TABLES-1:0][BUCKET_NBITS-1:0] ht_rdata_a;
  logic [NUM_TABLES-1:0][31:0] ht_prd;
  logic [NUM_TABLES-1:0] ht_ack_a;
  logic [31:0] v_prd, pio_rd;

  // Word address layout: {bank, entry, word}; bank only exists for hash.
  always_comb begin
    h_word = 8'(cap_waddr & HMASK);
    h_ent  = DEPTH_NBITS'(cap_waddr >> HWB);
    h_bank = cap_waddr >> (HWB + DEPTH_NBITS);
    v_word = 8'(cap_waddr & VMASK);
    v_ent  = VALUE_DEPTH_NBITS'(cap_waddr >> VWB);
    v_hi   = cap_waddr >> (VWB + VALUE_DEPTH_NBITS);
    h_in   = (32'(h_word) < 32'(words_per_entry(BUCKET_NBITS))) && (h_bank < 32'(NUM_TABLES));
    v_in   = (32'(v_word) < 32'(words_per_entry(VALUE_NBITS))) && (v_hi == '0);
    in_range = cap_hash ? h_in : v_in;
    for (int b = 0; b < NUM_TABLES; b++) hsel[b] = cap_hash && h_in && (h_bank == 32'(b));
    vsel   = !cap_hash && v_in;
    tgt_rd = (|(hsel & bus.ht_rd)) | (vsel & bus.value_rd);
    pio_rd = vsel ? v_prd : '0;
    for (int b = 0; b < NUM_TABLES; b++) if (hsel[b]) pio_rd = ht_prd[b];
  end

  assign force_gnt     = (state == ST_WAIT) && tgt_rd && (starve == CW'(STARVE_MAX));
  assign bus.ht_rdy    = ~(hsel & {NUM_TABLES{force_gnt}});
  assign bus.value_rdy = !(vsel && force_gnt);
  assign bus.reg_ack   = (state == ST_RESP);
  assign pio_we        = (state == ST_ACCESS) && cap_wr && `RESET_SIG;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if ((bus.reg_rd | bus.reg_wr) && (bus.reg_ms_hash | bus.reg_ms_value))
                   state_nxt = ST_WAIT;
      ST_WAIT:   if (!tgt_rd || starve == CW'(STARVE_MAX)) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

`ifdef RCI_MEM_PARITY_EN
  logic [NUM_TABLES-1:0] ht_aperr, ht_pperr;
  logic v_aperr, v_pperr, pio_perr_q;
  always_ff @(posedge clk) begin
    if (!`RESET_SIG)             pio_perr_q <= 1'b0;
    else if (state == ST_ACCESS) pio_perr_q <= !cap_wr && (|(hsel & ht_pperr) || (vsel && v_pperr));
  end
  assign bus.par_err = (|(ht_aperr & ht_ack_a)) | (v_aperr & bus.value_ack) | (bus.reg_ack & pio_perr_q);
`endif

  always_ff @(posedge clk) begin
    if (!`RESET_SIG) begin
      state         <= ST_IDLE;
      starve        <= '0;
      cap_waddr     <= '0;
      cap_din       <= '0;
      cap_wr        <= 1'b0;
      cap_hash      <= 1'b0;
      bus.reg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && state_nxt == ST_WAIT)
        starve <= (starve == CW'(STARVE_MAX)) ? starve : starve + 1'b1;
      else
        starve <= '0;
      if (state == ST_IDLE && state_nxt == ST_WAIT) begin
        cap_waddr <= 32'(bus.reg_addr >> 2);
        cap_din   <= 32'(bus.reg_din);
        cap_wr    <= bus.reg_wr;
        cap_hash  <= bus.reg_ms_hash;
      end
      if (state == ST_ACCESS)
        bus.reg_rdata <= (cap_wr || !in_range) ? '0 : pio_rd;
    end
  end

  for (genvar b = 0; b < NUM_TABLES; b++) begin : g_ht
    rci_mem_bank #(.W(BUCKET_NBITS), .AW(DEPTH_NBITS)) u_bank (
      .clk       (clk),
      .rst_n     (`RESET_SIG),
      .app_acc   (bus.ht_rd[b] & bus.ht_rdy[b]),
      .app_raddr (bus.ht_raddr[b*DEPTH_NBITS +: DEPTH_NBITS]),
      .app_ack   (ht_ack_a[b]),
      .app_rdata (ht_rdata_a[b]),
      .pio_we    (pio_we & hsel[b]),
      .pio_entry (h_ent),
      .pio_word  (h_word),
      .pio_wdata (cap_din),
      .pio_rdata (ht_prd[b])
`ifdef RCI_MEM_PARITY_EN
      ,
      .app_perr  (ht_aperr[b]),
      .pio_perr  (ht_pperr[b])
`endif
    );
  end

  assign bus.ht_rdata = ht_rdata_a;
  assign bus.ht_ack   = ht_ack_a;

  rci_mem_bank #(.W(VALUE_NBITS), .AW(VALUE_DEPTH_NBITS)) u_vbank (
    .clk       (clk),
    .rst_n     (`RESET_SIG),
    .app_acc   (bus.value_rd & bus.value_rdy),
    .app_raddr (bus.value_raddr),
    .app_ack   (bus.value_ack),
    .app_rdata (bus.value_rdata),
    .pio_we    (pio_we & vsel),
    .pio_entry (v_ent),
    .pio_word  (v_word),
    .pio_wdata (cap_din),
    .pio_rdata (v_prd)
`ifdef RCI_MEM_PARITY_EN
    ,
    .app_perr  (v_aperr),
    .pio_perr  (v_pperr)
`endif
  );
endmodule

// File: tb/tb_decap_rci_mem_arb.sv
// Directed bench for decap_rci_mem_arb (3-bit depths, 64-bit buckets, 48-bit values).
// Address map: value waddr = {entry,word}; hash waddr = {bank,entry,word}; byte addr = waddr<<2.
module tb_decap_rci_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic last_perr = 1'b0;

  always #5 clk = ~clk;

  decap_rci_mem_arb_if #(.NUM_TABLES(2), .DEPTH_NBITS(3), .BUCKET_NBITS(64),
                         .VALUE_NBITS(48), .VALUE_DEPTH_NBITS(3)) bus ();

  decap_rci_mem_arb #(.NUM_TABLES(2), .DEPTH_NBITS(3), .BUCKET_NBITS(64),
                      .VALUE_NBITS(48), .VALUE_DEPTH_NBITS(3), .STARVE_MAX(15)) dut (
    .clk        (clk),
    .`RESET_SIG (rst_n),
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one PIO op from IDLE and waits (bounded) for its ack cycle.
  task automatic pio(input bit wr, input bit rd, input bit hash, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rdat);
    bit seen;
    seen = 1'b0;
    rdat = '0;
    bus.reg_wr = wr; bus.reg_rd = rd; bus.reg_ms_hash = hash; bus.reg_ms_value = !hash;
    bus.reg_addr = a; bus.reg_din = d;
    @(posedge clk); #1;
    bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_ms_hash = 0; bus.reg_ms_value = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.reg_ack) begin
        seen = 1'b1;
        rdat = bus.reg_rdata;
`ifdef RCI_MEM_PARITY_EN
        last_perr = bus.par_err;
`endif
      end
    end
    chk("pio_ack", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic vread(input logic [2:0] a, output logic [47:0] d);
    bus.value_rd = 1; bus.value_raddr = a;
    @(posedge clk); #1;
    bus.value_rd = 0;
    @(negedge clk);
    @(negedge clk);
    chk("vread_ack", 64'(bus.value_ack), 64'd1);
    d = bus.value_rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [47:0] v;
    int lows, low_at, acks, ack_at;
    logic a18, a19;
    bus.reg_addr = '0; bus.reg_din = '0; bus.reg_rd = 0; bus.reg_wr = 0;
    bus.reg_ms_hash = 0; bus.reg_ms_value = 0;
    bus.ht_rd = '0; bus.ht_raddr = '0; bus.value_rd = 0; bus.value_raddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acks", {61'd0, bus.reg_ack, bus.ht_ack}, 64'd0);
    chk("rst_vack", 64'(bus.value_ack), 64'd0);
    chk("rst_rdata", 64'(bus.reg_rdata) | bus.value_rdata, 64'd0);
    chk("rst_htrdata", bus.ht_rdata[63:0] | bus.ht_rdata[127:64], 64'd0);
    chk("rst_rdy", {61'd0, bus.value_rdy, bus.ht_rdy}, 64'h7);
    @(posedge clk); #1 rst_n = 1;

    // Value entries 5 and 4; word 1 holds only 16 live bits.
    pio(1, 0, 0, 32'h28, 32'h11223344, r);
    chk("wr_rdata0", 64'(r), 64'd0);
    pio(1, 0, 0, 32'h2C, 32'hFFFFABCD, r);
    pio(1, 0, 0, 32'h20, 32'h55AA55AA, r);
    pio(1, 0, 0, 32'h24, 32'h00001234, r);
    pio(0, 1, 0, 32'h2C, 32'h0, r);
    chk("v_word1_trunc", 64'(r), 64'h0000ABCD);

    // Back-to-back app reads: addr 5 then 4, acks two cycles after each accept.
    bus.value_rd = 1; bus.value_raddr = 3'd5;
    @(negedge clk);
    chk("vack_n0", 64'(bus.value_ack), 64'd0);
    @(posedge clk); #1 bus.value_raddr = 3'd4;
    @(negedge clk);
    chk("vack_n1", 64'(bus.value_ack), 64'd0);
    @(posedge clk); #1 bus.value_rd = 0;
    @(negedge clk);
    chk("vack_n2", {15'd0, bus.value_ack, bus.value_rdata}, {15'd0, 1'b1, 48'hABCD_11223344});
    @(negedge clk);
    chk("vack_n3", {15'd0, bus.value_ack, bus.value_rdata}, {15'd0, 1'b1, 48'h1234_55AA55AA});
    @(negedge clk);
    chk("vhold_n4", {15'd0, bus.value_ack, bus.value_rdata}, {15'd0, 1'b0, 48'h1234_55AA55AA});
    @(posedge clk); #1;

    // Hash banks: same entry/word, different bank.
    pio(1, 0, 1, 32'h18, 32'h0BADF00D, r);
    pio(1, 0, 1, 32'h58, 32'hDEADBEEF, r);
    pio(0, 1, 1, 32'h58, 32'h0, r);
    chk("h1_e3_rd", 64'(r), 64'hDEADBEEF);
    pio(0, 1, 1, 32'h18, 32'h0, r);
    chk("h0_e3_kept", 64'(r), 64'h0BADF00D);
    bus.ht_rd = 2'b10; bus.ht_raddr = {3'd3, 3'd0};
    @(posedge clk); #1 bus.ht_rd = '0;
    @(negedge clk);
    @(negedge clk);
    chk("ht1_app", {30'd0, bus.ht_ack, bus.ht_rdata[95:64]}, {30'd0, 2'b10, 32'hDEADBEEF});
    @(posedge clk); #1;

    // Starvation: bank 0 read every cycle while PIO reads bank 0.
    lows = 0; low_at = 0; acks = 0; ack_at = 0; a18 = 1'bx; a19 = 1'bx; r = '0;
    bus.ht_rd = 2'b01; bus.ht_raddr = {3'd0, 3'd3};
    bus.reg_rd = 1; bus.reg_ms_hash = 1; bus.reg_addr = 32'h18;
    @(posedge clk); #1;
    bus.reg_rd = 0; bus.reg_ms_hash = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!bus.ht_rdy[0]) begin lows++; low_at = i; end
      if (bus.reg_ack) begin acks++; ack_at = i; r = bus.reg_rdata; end
      if (i == 18) a18 = bus.ht_ack[0];
      if (i == 19) a19 = bus.ht_ack[0];
    end
    chk("starve_lows", 64'(lows), 64'd1);
    chk("starve_low_at", 64'(low_at), 64'd16);
    chk("starve_acks", 64'(acks), 64'd1);
    chk("starve_ack_at", 64'(ack_at), 64'd18);
    chk("starve_rdata", 64'(r), 64'h0BADF00D);
    chk("app_gap", {62'd0, a18, a19}, 64'b01);
    chk("app_data", 64'(bus.ht_rdata[31:0]), 64'h0BADF00D);
    @(posedge clk); #1 bus.ht_rd = '0;
    @(posedge clk); #1;

    // rd and wr together behave as a write.
    pio(1, 1, 0, 32'h04, 32'h00005A5A, r);
    chk("rdwr_rdata", 64'(r), 64'd0);
    pio(0, 1, 0, 32'h04, 32'h0, r);
    chk("rdwr_stored", 64'(r), 64'h5A5A);

    // Out-of-range: value waddr 16 would alias entry 0 word 0 if not dropped.
    pio(1, 0, 0, 32'h00, 32'hCAFEF00D, r);
    pio(1, 0, 0, 32'h40, 32'hFFFFFFFF, r);
    chk("oor_wr_rdata", 64'(r), 64'd0);
    pio(0, 1, 0, 32'h40, 32'h0, r);
    chk("oor_rd_rdata", 64'(r), 64'd0);
    pio(0, 1, 1, 32'h80, 32'h0, r);
    chk("oor_hash_rd", 64'(r), 64'd0);
    pio(0, 1, 0, 32'h00, 32'h0, r);
    chk("oor_no_alias", 64'(r), 64'hCAFEF00D);

    // App read of entry 5 in the same cycle PIO writes it returns old data.
    bus.reg_wr = 1; bus.reg_ms_value = 1; bus.reg_addr = 32'h28; bus.reg_din = 32'h99999999;
    @(posedge clk); #1 bus.reg_wr = 0; bus.reg_ms_value = 0;
    @(posedge clk); #1 bus.value_rd = 1; bus.value_raddr = 3'd5;
    @(posedge clk); #1 bus.value_rd = 0;
    @(negedge clk);
    chk("coll_reg_ack", 64'(bus.reg_ack), 64'd1);
    @(negedge clk);
    chk("coll_old", {15'd0, bus.value_ack, bus.value_rdata}, {15'd0, 1'b1, 48'hABCD_11223344});
    @(posedge clk); #1;
    vread(3'd5, v);
    chk("coll_new", 64'(v), 64'hABCD_99999999);

    // Reset in ACCESS: op abandoned, no ack, then normal operation.
    bus.reg_wr = 1; bus.reg_ms_value = 1; bus.reg_addr = 32'h00; bus.reg_din = 32'h12345678;
    @(posedge clk); #1 bus.reg_wr = 0; bus.reg_ms_value = 0;
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.reg_ack) acks++;
    end
    chk("rst_access_noack", 64'(acks), 64'd0);
    chk("rst_access_rdy", {61'd0, bus.value_rdy, bus.ht_rdy}, 64'h7);
    @(posedge clk); #1;
    pio(0, 1, 0, 32'h00, 32'h0, r);
    chk("rst_access_dropped", 64'(r), 64'hCAFEF00D);
    pio(1, 0, 0, 32'h00, 32'h12345678, r);
    pio(0, 1, 0, 32'h00, 32'h0, r);
    chk("post_rst_op", 64'(r), 64'h12345678);

`ifdef RCI_MEM_PARITY_EN
    pio(0, 1, 0, 32'h28, 32'h0, r);
    chk("par_clean", 64'(last_perr), 64'd0);
    dut.u_vbank.mem[5][0] = ~dut.u_vbank.mem[5][0];
    pio(0, 1, 0, 32'h28, 32'h0, r);
    chk("par_err", 64'(last_perr), 64'd1);
    chk("par_data", 64'(r), 64'h99999998);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decap_rci_mem_arb.md
DECAP_RCI_MEM_ARB -- requirements
Module: decap_rci_mem_arb

Interface
REQ-001 SHALL have parameter NUM_TABLES, default 2: number of hash-table banks.
REQ-002 SHALL have parameter DEPTH_NBITS, default `RCI_HASH_TABLE_DEPTH_NBITS: hash-bank address width.
REQ-003 SHALL have parameter BUCKET_NBITS, default `RCI_HASH_BUCKET_NBITS: hash entry width.
REQ-004 SHALL have parameter VALUE_NBITS, default `RCI_VALUE_NBITS: value entry width, any positive width.
REQ-005 SHALL have parameter VALUE_DEPTH_NBITS, default `RCI_VALUE_DEPTH_NBITS: value address width.
REQ-006 SHALL have parameter STARVE_MAX, default 15: blocked-PIO cycles before a forced grant.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-low.
REQ-008 SHALL have port `RESET_SIG, input, 1 bit: the active-low synchronous reset.
REQ-009 SHALL have ports reg_addr, reg_din, reg_rdata (`PIO_RANGE); reg_rd, reg_wr, reg_ms_hash, reg_ms_value inputs, 1 bit; reg_ack output, 1 bit.
REQ-010 SHALL have ports ht_rd[NUM_TABLES] input, ht_raddr[NUM_TABLES*DEPTH_NBITS] input, ht_rdy/ht_ack[NUM_TABLES] output, ht_rdata[NUM_TABLES*BUCKET_NBITS] output.
REQ-011 SHALL have ports value_rd input, 1 bit; value_raddr input, VALUE_DEPTH_NBITS; value_rdy and value_ack outputs, 1 bit; value_rdata output, VALUE_NBITS.

Function
REQ-012 SHALL store each entry as ceil(width/32) 32-bit PIO words; word select = reg_addr[MSB:2] low bits, then entry index; for hash, bank index sits above entry index.
REQ-013 SHALL complete an app read accepted (rd & rdy) in cycle N with ack pulse and data valid in cycle N+2; back-to-back reads every cycle are sustained.
REQ-014 SHALL hold rdata stable from ack until the next ack of that port.
REQ-015 SHALL run a PIO FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE; strobes are sampled only in IDLE.
REQ-016 SHALL, in IDLE, on (reg_rd|reg_wr) with reg_ms_hash or reg_ms_value, capture addr/din/op and go to WAIT.
REQ-017 SHALL, in WAIT, go to ACCESS when the target bank sees no app read that cycle, or when the starve counter reaches STARVE_MAX.
REQ-018 SHALL deassert the target bank's rdy for exactly the forced-grant cycle; app ports never lose an accepted read.
REQ-019 SHALL perform the word write or read in ACCESS; RESP pulses reg_ack for one cycle with reg_rdata (0 for writes).
REQ-020 SHALL treat reg_rd & reg_wr together as a write.
REQ-021 SHALL ack out-of-range addresses with reg_rdata 0 and drop the write.
REQ-022 SHALL reset the starve counter on leaving WAIT; the counter saturates and does not wrap.
REQ-023 SHALL, when PIO writes the same entry an app read hits in the same cycle, give the app the pre-write data.

Reset
REQ-024 SHALL on reset drive reg_ack, all ht_ack and value_ack to 0, all rdata to 0, all rdy to 1, FSM to IDLE and the counter to 0.
REQ-025 SHALL abandon an in-flight PIO op on reset without ack; array contents are not reset.

Configuration
REQ-026 SHALL, with RCI_MEM_PARITY_EN defined, store one even-parity bit per 32-bit word, check it on every read and pulse output par_err (1 bit, reset 0) in the ack cycle; without it, no parity storage exists and par_err is absent.

Structure
REQ-027 SHALL place words-per-entry functions, FSM state encoding and the PIO word constant (32) in a shared package.
REQ-028 SHALL use one sub-module, rci_mem_bank, instantiated per hash bank and once for values: a one-app-read-port, one-PIO-port array with 2-cycle read pipeline.

Verification
REQ-029 SHALL cover: value_rd at addr 5 in cycle 10 -> value_ack and stored data in cycle 12.
REQ-030 SHALL cover: PIO write 0xDEADBEEF to hash bank 1 entry 3 word 0, then PIO read -> reg_rdata 0xDEADBEEF, bank 0 entry 3 unchanged.
REQ-031 SHALL cover: ht_rd[0] held high continuously with PIO read to bank 0 -> ht_rdy[0] low for one cycle after 15 blocked cycles, reg_ack follows.
REQ-032 SHALL cover: out-of-range value address write then read -> both acked, rdata 0, no array change.
REQ-033 SHALL cover: reset asserted in ACCESS -> no reg_ack, FSM IDLE, next PIO op completes normally.
REQ-034 SHALL cover (parity build): flip one stored bit via backdoor, read -> par_err pulses with ack.
